// File: rtl/params_pkg.sv
// params_pkg: shared memory-system parameters and the data-memory
// controller state encoding.
package params_pkg;

   localparam int unsigned MEM_SIZE    = 4096;
   localparam int unsigned ADDR_WIDTH  = 32;
   localparam int unsigned MEM_LATENCY = 5;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_WAIT  = 2'd1,
      WRITE_WAIT = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: byte-organised backing store with one synchronous
// line-wide read port and one line-wide write port, both indexed by line.
module dmem_line_array #(
   parameter int unsigned MEM_SIZE   = 4096,
   parameter int unsigned LINE_BYTES = 16,
   parameter int unsigned IDX_W      = 8
) (
   input  logic                      i_clk,
   input  logic [IDX_W-1:0]          i_rd_idx,
   output logic [LINE_BYTES*8-1:0]   o_rd_line,
   input  logic                      i_we,
   input  logic [IDX_W-1:0]          i_wr_idx,
   input  logic [LINE_BYTES*8-1:0]   i_wr_line
);

   localparam int unsigned OFF_W = $clog2(LINE_BYTES);

   logic [7:0] r_mem [MEM_SIZE];

   // commit a whole line, byte 0 at the lowest address
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int unsigned b = 0; b < LINE_BYTES; b++) begin
            r_mem[{i_wr_idx, OFF_W'(b)}] <= i_wr_line[b*8 +: 8];
         end
      end
   end

   // registered line read, refreshed every cycle
   always_ff @(posedge i_clk) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
         o_rd_line[b*8 +: 8] <= r_mem[{i_rd_idx, OFF_W'(b)}];
      end
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: main-memory responder for cache line refill/write-back.
// One line transaction at a time, fixed latency MEM_LATENCY from grant.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (adds addr_err_o, out-of-range
// accesses return a zero line / drop the write instead of wrapping).
module data_mem_ctrl #(
   parameter int unsigned MEM_SIZE    = params_pkg::MEM_SIZE,
   parameter int unsigned ADDR_WIDTH  = params_pkg::ADDR_WIDTH,
   parameter int unsigned LINE_BYTES  = 16,
   parameter int unsigned MEM_LATENCY = params_pkg::MEM_LATENCY
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      rd_req_valid_i,
   input  logic                      wr_req_valid_i,
   input  logic [ADDR_WIDTH-1:0]     mem_req_address_i,
   input  logic [LINE_BYTES*8-1:0]   wr_line_data_i,
   output logic                      mem_gnt_o,
   output logic                      mem_rvalid_o,
   output logic [LINE_BYTES*8-1:0]   mem_line_data_o,
   output logic                      write_done_o,
   output logic                      busy_o
`ifdef DMEM_BOUNDS_CHECK_EN
   ,
   output logic                      addr_err_o
`endif
);

   import params_pkg::*;

   localparam int unsigned LINE_W    = LINE_BYTES * 8;
   localparam int unsigned OFF_W     = $clog2(LINE_BYTES);
   localparam int unsigned NUM_LINES = MEM_SIZE / LINE_BYTES;
   localparam int unsigned IDX_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int unsigned MEM_AW    = $clog2(MEM_SIZE);
   localparam int unsigned CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   dmem_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [LINE_W-1:0]  r_wr_line;
   logic [LINE_W-1:0]  r_line;
   logic               r_oob;

   logic               w_req_any;
   logic               w_gnt;
   logic               w_rvalid;
   logic               w_wdone;
   logic [IDX_W-1:0]   w_req_idx;
   logic [IDX_W-1:0]   w_arr_rd_idx;
   logic [LINE_W-1:0]  w_arr_line;
   logic [LINE_W-1:0]  w_rd_line;
   logic               w_req_oob;
   logic               w_arr_we;
   logic               w_unused_addr;

   assign w_req_any = rd_req_valid_i | wr_req_valid_i;
   assign w_req_idx = mem_req_address_i[OFF_W +: IDX_W];

`ifdef DMEM_BOUNDS_CHECK_EN
   assign w_req_oob     = |mem_req_address_i[ADDR_WIDTH-1:MEM_AW];
   assign w_rd_line     = r_oob ? '0 : w_arr_line;
   assign w_arr_we      = w_wdone & ~r_oob;
   assign addr_err_o    = (w_rvalid | w_wdone) & r_oob;
   assign w_unused_addr = ^mem_req_address_i[OFF_W-1:0];
`else
   assign w_req_oob     = 1'b0;
   assign w_rd_line     = w_arr_line;
   assign w_arr_we      = w_wdone;
   assign w_unused_addr = ^{mem_req_address_i[ADDR_WIDTH-1:MEM_AW],
                            mem_req_address_i[OFF_W-1:0], r_oob};
`endif

   // The array read is synchronous, so while IDLE it is pointed at the
   // incoming request; that makes the line ready even for MEM_LATENCY=1.
   assign w_arr_rd_idx = (r_state == IDLE) ? w_req_idx : r_idx;

   dmem_line_array #(
      .MEM_SIZE   (MEM_SIZE),
      .LINE_BYTES (LINE_BYTES),
      .IDX_W      (IDX_W)
   ) u_array (
      .i_clk     (clk_i),
      .i_rd_idx  (w_arr_rd_idx),
      .o_rd_line (w_arr_line),
      .i_we      (w_arr_we),
      .i_wr_idx  (r_idx),
      .i_wr_line (r_wr_line)
   );

   // next-state, grant and response pulses; all suppressed while in reset
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gnt       = 1'b0;
      w_rvalid    = 1'b0;
      w_wdone     = 1'b0;
      case (r_state)
         IDLE: begin
            w_gnt = w_req_any;
            if (w_req_any) begin
               w_cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
               w_state_nxt = wr_req_valid_i ? WRITE_WAIT : READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (r_cnt == '0) begin
               w_rvalid    = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         WRITE_WAIT: begin
            if (r_cnt == '0) begin
               w_wdone     = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (rst_i) begin
         w_gnt    = 1'b0;
         w_rvalid = 1'b0;
         w_wdone  = 1'b0;
      end
   end

   // state, counter and transaction latches
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_wr_line <= '0;
         r_oob     <= 1'b0;
         r_line    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_gnt) begin
            r_idx     <= w_req_idx;
            r_wr_line <= wr_line_data_i;
            r_oob     <= w_req_oob;
         end
         if (w_rvalid) begin
            r_line <= w_rd_line;
         end
      end
   end

`ifdef DMEM_BOUNDS_CHECK_EN
`ifndef SYNTHESIS
   // report out-of-range accesses in simulation
   always_ff @(posedge clk_i) begin
      if (addr_err_o) begin
         $error("data_mem_ctrl: access beyond MEM_SIZE (line index %0d)", r_idx);
      end
   end
`endif
`endif

   assign mem_gnt_o       = w_gnt;
   assign mem_rvalid_o    = w_rvalid;
   assign write_done_o    = w_wdone;
   assign busy_o          = (r_state != IDLE) & ~rst_i;
   assign mem_line_data_o = w_rvalid ? w_rd_line : r_line;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scenario tasks with a scoreboard queue of expected
// responses and a line-level memory model.
module tb_data_mem_ctrl;

   import params_pkg::*;

   localparam int unsigned LB  = 16;
   localparam int unsigned LAT = MEM_LATENCY;

   typedef struct {
      bit           is_wr;
      logic [127:0] line;
      bit           err;
   } exp_t;

   logic                  clk;
   logic                  rst;
   logic                  rd_req;
   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] addr;
   logic [127:0]          wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [127:0]          rdata;
   logic                  wdone;
   logic                  busy;
   logic                  aerr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   exp_t         sbq[$];
   logic [127:0] model [int unsigned];

   data_mem_ctrl #(
      .MEM_SIZE    (MEM_SIZE),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .LINE_BYTES  (LB),
      .MEM_LATENCY (LAT)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .rd_req_valid_i    (rd_req),
      .wr_req_valid_i    (wr_req),
      .mem_req_address_i (addr),
      .wr_line_data_i    (wdata),
      .mem_gnt_o         (gnt),
      .mem_rvalid_o      (rvalid),
      .mem_line_data_o   (rdata),
      .write_done_o      (wdone),
      .busy_o            (busy)
`ifdef DMEM_BOUNDS_CHECK_EN
      ,
      .addr_err_o        (aerr)
`endif
   );

`ifndef DMEM_BOUNDS_CHECK_EN
   assign aerr = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned lidx(input logic [ADDR_WIDTH-1:0] a);
      return (int'(a) % MEM_SIZE) / LB;
   endfunction

   function automatic bit is_oob(input logic [ADDR_WIDTH-1:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
      return a >= ADDR_WIDTH'(MEM_SIZE);
`else
      return (a == a) ? 1'b0 : 1'b0;
`endif
   endfunction

   // Drive a request, wait (bounded) for the grant, record the expected
   // response in the scoreboard and update the model for writes.
   task automatic issue(input bit wr, input bit rd, input logic [ADDR_WIDTH-1:0] a,
                        input logic [127:0] line, input bit track, input bit keep_rd,
                        output int gc);
      exp_t e;
      @(posedge clk); #1;
      wr_req = wr; rd_req = rd; addr = a; wdata = line;
      gc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt === 1'b1) begin
            gc = cyc;
            break;
         end
      end
      total++;
      if (gc < 0) begin
         bad++;
         $display("FAIL grant_timeout: got no grant, required grant within 20 cycles (addr %h)", a);
      end else if (track) begin
         e.err = is_oob(a);
         if (wr) begin
            e.is_wr = 1'b1;
            e.line  = line;
            if (!e.err) model[lidx(a)] = line;
         end else begin
            e.is_wr = 1'b0;
            e.line  = e.err ? 128'h0 : model[lidx(a)];
         end
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      wr_req = 1'b0;
      rd_req = keep_rd;
   endtask

   // Follow one transaction through its wait cycles; pop and compare the
   // scoreboard entry when the response pulse is due.
   task automatic wait_resp();
      exp_t e;
      for (int k = 1; k <= int'(LAT); k++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_in_wait: got %b required 1 (k=%0d)", busy, k);
         end
         total++;
         if (gnt !== 1'b0) begin
            bad++; $display("FAIL gnt_in_wait: got %b required 0 (k=%0d)", gnt, k);
         end
         if (k < int'(LAT)) begin
            total++;
            if ({rvalid, wdone} !== 2'b00) begin
               bad++; $display("FAIL early_pulse: got rvalid/wdone=%b%b required 00 (k=%0d)", rvalid, wdone, k);
            end
         end else begin
            total++;
            if (sbq.size() == 0) begin
               bad++; $display("FAIL scoreboard_empty: got empty queue, required an entry");
            end else begin
               e = sbq.pop_front();
               if ({rvalid, wdone} !== {~e.is_wr, e.is_wr}) begin
                  bad++; $display("FAIL resp_pulse: got rvalid/wdone=%b%b required %b%b",
                                  rvalid, wdone, ~e.is_wr, e.is_wr);
               end
               if (!e.is_wr) begin
                  total++;
                  if (rdata !== e.line) begin
                     bad++; $display("FAIL read_data: got %h required %h", rdata, e.line);
                  end
               end
               total++;
               if (aerr !== e.err) begin
                  bad++; $display("FAIL addr_err: got %b required %b", aerr, e.err);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if ({gnt, rvalid, wdone, busy, aerr} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl: got gnt/rv/wd/busy/err=%b required 00000",
                         {gnt, rvalid, wdone, busy, aerr});
      end
      total++;
      if (rdata !== 128'h0) begin
         bad++; $display("FAIL reset_data: got %h required 0", rdata);
      end
   endtask

   task automatic test_write_read();
      int gc;
      issue(1'b1, 1'b0, 'h40, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 1'b0, gc);
      wait_resp();
      issue(1'b0, 1'b1, 'h4C, '0, 1'b1, 1'b0, gc);
      wait_resp();
      // line must be held after the pulse
      @(negedge clk);
      total++;
      if (rdata !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
         bad++; $display("FAIL read_hold: got %h required 00112233445566778899aabbccddeeff", rdata);
      end
   endtask

   task automatic test_both();
      int g1, g2;
      issue(1'b1, 1'b1, 'h80, 128'hA5A5A5A5_12345678_DEADBEEF_0F1E2D3C, 1'b1, 1'b1, g1);
      wait_resp();
      issue(1'b0, 1'b1, 'h80, '0, 1'b1, 1'b0, g2);
      total++;
      if (g2 - g1 != int'(LAT) + 1) begin
         bad++; $display("FAIL both_regrant_gap: got %0d required %0d", g2 - g1, LAT + 1);
      end
      wait_resp();
   endtask

   task automatic test_hold();
      int g1, g2, extra;
      issue(1'b0, 1'b1, 'h40, '0, 1'b1, 1'b1, g1);
      wait_resp();
      issue(1'b0, 1'b1, 'h40, '0, 1'b1, 1'b0, g2);
      total++;
      if (g2 - g1 != int'(LAT) + 1) begin
         bad++; $display("FAIL hold_regrant_gap: got %0d required %0d", g2 - g1, LAT + 1);
      end
      wait_resp();
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rvalid === 1'b1 || wdone === 1'b1 || gnt === 1'b1 || busy === 1'b1) extra++;
      end
      total++;
      if (extra != 0) begin
         bad++; $display("FAIL hold_extra_activity: got %0d active cycles required 0", extra);
      end
   endtask

   task automatic test_reset_mid();
      int gc, pulses;
      issue(1'b1, 1'b0, 'hC0, 128'h11111111_22222222_33333333_44444444, 1'b1, 1'b0, gc);
      wait_resp();
      issue(1'b1, 1'b0, 'hC0, 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC, 1'b0, 1'b0, gc);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (wdone === 1'b1 || rvalid === 1'b1 || busy === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++; $display("FAIL reset_mid_pulse: got %0d active cycles required 0", pulses);
      end
      total++;
      if (rdata !== 128'h0) begin
         bad++; $display("FAIL reset_mid_data: got %h required 0", rdata);
      end
      issue(1'b0, 1'b1, 'hC0, '0, 1'b1, 1'b0, gc);
      wait_resp();
   endtask

   task automatic test_bounds();
      int gc;
      issue(1'b1, 1'b0, 'h0, 128'h0BADF00D_CAFEBABE_01020304_05060708, 1'b1, 1'b0, gc);
      wait_resp();
      issue(1'b0, 1'b1, ADDR_WIDTH'(MEM_SIZE), '0, 1'b1, 1'b0, gc);
      wait_resp();
`ifdef DMEM_BOUNDS_CHECK_EN
      issue(1'b1, 1'b0, ADDR_WIDTH'(MEM_SIZE), 128'h99999999_88888888_77777777_66666666, 1'b1, 1'b0, gc);
      wait_resp();
      issue(1'b0, 1'b1, 'h0, '0, 1'b1, 1'b0, gc);
      wait_resp();
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_both();
      test_hold();
      test_reset_mid();
      test_bounds();
      total++;
      if (sbq.size() != 0) begin
         bad++; $display("FAIL scoreboard_leftover: got %0d entries required 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, required finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
